// File: rtl/masked_sbox_state_sequencer.sv
// masked_sbox_state_sequencer
//   Drives an external 3-share, second-order masked AES S-box over a full
//   128-bit state. Each cycle with fresh randomness, one byte's three shares
//   are issued to the S-box. A tag pipeline the same depth as the S-box
//   follows every issued byte, so each returning result is written back to
//   the right byte of the result shares. The three shares are only ever
//   moved between registers; they are never combined.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start                    one-cycle request, accepted only in IDLE
//   busy                     high from start acceptance until done
//   done                     one-cycle pulse, state_out_* valid
//   state_in_share1..3       input shares (byte k = bits [8k+7:8k])
//   state_out_share1..3      result shares, held until next accepted start
//   rand_valid / rand_ready  fresh randomness present / consumed (= busy)
//   rand_in                  per-cycle randomness for the three S-box stages
//   sb_in_share1..3          byte shares to the S-box (0 when not issuing)
//   sb_rand_cycle1..3        rand_in slices routed to S-box stages 1..3
//   sb_out_share1..3         S-box output shares
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | issuing one byte per cycle while rand_valid is high
// DRAIN  | all bytes issued, waiting for in-flight results
// DONE   | done pulse, result shares valid
module masked_sbox_state_sequencer #(
  parameter int SBOX_LATENCY = 3,
  parameter int NBYTES       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [8*NBYTES-1:0] state_in_share1,
  input  logic [8*NBYTES-1:0] state_in_share2,
  input  logic [8*NBYTES-1:0] state_in_share3,
  output logic [8*NBYTES-1:0] state_out_share1,
  output logic [8*NBYTES-1:0] state_out_share2,
  output logic [8*NBYTES-1:0] state_out_share3,
  input  logic              rand_valid,
  output logic              rand_ready,
  input  logic [137:0]      rand_in,
  output logic [7:0]        sb_in_share1,
  output logic [7:0]        sb_in_share2,
  output logic [7:0]        sb_in_share3,
  output logic [53:0]       sb_rand_cycle1,
  output logic [59:0]       sb_rand_cycle2,
  output logic [23:0]       sb_rand_cycle3,
  input  logic [7:0]        sb_out_share1,
  input  logic [7:0]        sb_out_share2,
  input  logic [7:0]        sb_out_share3
);

  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int SW    = 8 * NBYTES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  state;
  logic [SW-1:0]           in1_q;
  logic [SW-1:0]           in2_q;
  logic [SW-1:0]           in3_q;
  logic [IDX_W-1:0]        idx;
  logic [SBOX_LATENCY-1:0] tag_valid;
  logic [IDX_W-1:0]        tag_idx [SBOX_LATENCY];

  logic                    issue;
  logic [IDX_W-1:0]        cap_idx;
  logic                    older_tags_idle;

  assign issue   = (state == S_ISSUE) && rand_valid;
  assign cap_idx = tag_idx[SBOX_LATENCY-1];

  // The oldest tag is written back on the same edge that leaves DRAIN, so
  // only the younger stages need to be empty.
  assign older_tags_idle = (tag_valid[SBOX_LATENCY-2:0] == '0);

  // Bytes are presented in the same cycle rand_valid is seen, so stage-1
  // randomness that cycle is guaranteed fresh for a real issue.
  assign sb_in_share1 = issue ? in1_q[{idx, 3'b000} +: 8] : 8'h00;
  assign sb_in_share2 = issue ? in2_q[{idx, 3'b000} +: 8] : 8'h00;
  assign sb_in_share3 = issue ? in3_q[{idx, 3'b000} +: 8] : 8'h00;

  assign rand_ready     = busy;
  assign sb_rand_cycle1 = rand_in[53:0];
  assign sb_rand_cycle2 = rand_in[113:54];
  assign sb_rand_cycle3 = rand_in[137:114];

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      idx              <= '0;
      in1_q            <= '0;
      in2_q            <= '0;
      in3_q            <= '0;
      state_out_share1 <= '0;
      state_out_share2 <= '0;
      state_out_share3 <= '0;
      tag_valid        <= '0;
      for (int i = 0; i < SBOX_LATENCY; i++) tag_idx[i] <= '0;
    end else begin
      // Tag pipeline advances every cycle; bubbles carry valid = 0.
      tag_valid  <= {tag_valid[SBOX_LATENCY-2:0], issue};
      tag_idx[0] <= idx;
      for (int i = 1; i < SBOX_LATENCY; i++) tag_idx[i] <= tag_idx[i-1];

      if (tag_valid[SBOX_LATENCY-1]) begin
        state_out_share1[{cap_idx, 3'b000} +: 8] <= sb_out_share1;
        state_out_share2[{cap_idx, 3'b000} +: 8] <= sb_out_share2;
        state_out_share3[{cap_idx, 3'b000} +: 8] <= sb_out_share3;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            in1_q            <= state_in_share1;
            in2_q            <= state_in_share2;
            in3_q            <= state_in_share3;
            state_out_share1 <= '0;
            state_out_share2 <= '0;
            state_out_share3 <= '0;
            idx              <= '0;
            busy             <= 1'b1;
            state            <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue) begin
            idx <= idx + 1'b1;
            if (idx == LAST_IDX) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (older_tags_idle) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_masked_sbox_state_sequencer.sv
module tb_masked_sbox_state_sequencer;

  logic         clk = 1'b0;
  logic         rst, start, busy, done, rand_valid, rand_ready;
  logic [127:0] state_in_share1, state_in_share2, state_in_share3;
  logic [127:0] state_out_share1, state_out_share2, state_out_share3;
  logic [137:0] rand_in;
  logic [7:0]   sb_in_share1, sb_in_share2, sb_in_share3;
  logic [7:0]   sb_out_share1, sb_out_share2, sb_out_share3;
  logic [53:0]  sb_rand_cycle1;
  logic [59:0]  sb_rand_cycle2;
  logic [23:0]  sb_rand_cycle3;

  always #5 clk = ~clk;

  masked_sbox_state_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .state_in_share1(state_in_share1), .state_in_share2(state_in_share2),
    .state_in_share3(state_in_share3),
    .state_out_share1(state_out_share1), .state_out_share2(state_out_share2),
    .state_out_share3(state_out_share3),
    .rand_valid(rand_valid), .rand_ready(rand_ready), .rand_in(rand_in),
    .sb_in_share1(sb_in_share1), .sb_in_share2(sb_in_share2),
    .sb_in_share3(sb_in_share3),
    .sb_rand_cycle1(sb_rand_cycle1), .sb_rand_cycle2(sb_rand_cycle2),
    .sb_rand_cycle3(sb_rand_cycle3),
    .sb_out_share1(sb_out_share1), .sb_out_share2(sb_out_share2),
    .sb_out_share3(sb_out_share3)
  );

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // AES S-box from its definition: GF(2^8) inverse then affine map.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] aes_sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // External masked S-box stand-in: three register stages, fresh output masks.
  logic [23:0] sb_pipe [3];
  logic [7:0]  sb_x, sb_y, sb_m1, sb_m2;
  always @(posedge clk) begin
    sb_x  = sb_in_share1 ^ sb_in_share2 ^ sb_in_share3;
    sb_y  = aes_sbox(sb_x);
    sb_m1 = 8'($urandom);
    sb_m2 = 8'($urandom);
    sb_pipe[0] <= {sb_m1, sb_m2, sb_y ^ sb_m1 ^ sb_m2};
    sb_pipe[1] <= sb_pipe[0];
    sb_pipe[2] <= sb_pipe[1];
  end
  assign sb_out_share1 = sb_pipe[2][23:16];
  assign sb_out_share2 = sb_pipe[2][15:8];
  assign sb_out_share3 = sb_pipe[2][7:0];

  // Behavioural model: counts issued bytes, then waits the S-box latency.
  bit           m_active = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  int           m_issued = 0, m_tail = 0, m_out_mode = 0;
  logic [127:0] m_a = '0, m_b = '0, m_c = '0, m_exp = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      m_issued = 0; m_tail = 0; m_out_mode = 1;
    end else if (m_done) begin
      m_done = 1'b0;
      m_active = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1; m_busy = 1'b1;
        m_a = state_in_share1; m_b = state_in_share2; m_c = state_in_share3;
        m_issued = 0; m_tail = 0; m_out_mode = 1;
        for (int k = 0; k < 16; k++)
          m_exp[8*k +: 8] = aes_sbox(m_a[8*k +: 8] ^ m_b[8*k +: 8] ^ m_c[8*k +: 8]);
      end
    end else begin
      if (m_out_mode == 1) m_out_mode = 0;
      if (m_issued < 16) begin
        if (rand_valid) m_issued++;
      end else begin
        m_tail++;
        if (m_tail == 3) begin
          m_done = 1'b1; m_busy = 1'b0; m_out_mode = 2;
        end
      end
    end
  end

  logic [7:0] e1, e2, e3;
  always @(negedge clk) begin
    if (chk_en) begin
      e1 = 8'h00; e2 = 8'h00; e3 = 8'h00;
      if (m_busy && m_issued < 16 && rand_valid) begin
        e1 = m_a[8*m_issued +: 8];
        e2 = m_b[8*m_issued +: 8];
        e3 = m_c[8*m_issued +: 8];
      end
      chk("busy", 128'(busy), 128'(m_busy));
      chk("done", 128'(done), 128'(m_done));
      chk("rand_ready", 128'(rand_ready), 128'(m_busy));
      chk("sb_in_share1", 128'(sb_in_share1), 128'(e1));
      chk("sb_in_share2", 128'(sb_in_share2), 128'(e2));
      chk("sb_in_share3", 128'(sb_in_share3), 128'(e3));
      chk("sb_rand_cycle1", 128'(sb_rand_cycle1), 128'(rand_in[53:0]));
      chk("sb_rand_cycle2", 128'(sb_rand_cycle2), 128'(rand_in[113:54]));
      chk("sb_rand_cycle3", 128'(sb_rand_cycle3), 128'(rand_in[137:114]));
      if (m_out_mode == 1) begin
        chk("out1_zero", state_out_share1, 128'h0);
        chk("out2_zero", state_out_share2, 128'h0);
        chk("out3_zero", state_out_share3, 128'h0);
      end else if (m_out_mode == 2) begin
        chk("unmasked_out", state_out_share1 ^ state_out_share2 ^ state_out_share3, m_exp);
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rand_in = 138'({$urandom, $urandom, $urandom, $urandom, $urandom});
  endtask

  // Accept a start, then keep rand_valid high except for a stall window.
  // Returns in the done cycle with the edge count from acceptance (inclusive).
  task automatic run(input logic [127:0] a, input logic [127:0] b, input logic [127:0] c,
                     input int stall_at, input int stall_len, input bit dup_start,
                     output int lat);
    int n;
    state_in_share1 = a; state_in_share2 = b; state_in_share3 = c;
    start = 1'b1; rand_valid = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 80) begin
      rand_valid = !(n >= stall_at && n < stall_at + stall_len);
      if (dup_start && n == 5) begin
        start = 1'b1;
        state_in_share1 = ~a; state_in_share2 = a ^ b; state_in_share3 = 128'h5a;
      end
      if (dup_start && n == 6) start = 1'b0;
      tick();
      n++;
    end
    rand_valid = 1'b1;
    lat = n + 1;
    chk("done_seen", 128'(done), 128'h1);
  endtask

  localparam logic [127:0] LIT_ROW0 = 128'h76abd7fe_2b670130_c56f6bf2_7b777c63;
  localparam logic [127:0] LIT_ROW1 = 128'hc072a49c_afa2d4ad_f04759fa_7dc982ca;
  localparam logic [127:0] ALL_63   = {16{8'h63}};
  localparam logic [127:0] SEQ_ROW0 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [127:0] SEQ_ROW1 = 128'h1f1e1d1c_1b1a1918_17161514_13121110;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, dc;
    logic [127:0] ra, rb;
    rst = 1'b1; start = 1'b0; rand_valid = 1'b0;
    state_in_share1 = '0; state_in_share2 = '0; state_in_share3 = '0;
    rand_in = '0;
    tick();
    tick();
    chk_en = 1'b1;
    chk("reset_busy", 128'(busy), 128'h0);
    chk("reset_done", 128'(done), 128'h0);
    chk("reset_out1", state_out_share1, 128'h0);
    chk("reset_out2", state_out_share2, 128'h0);
    chk("reset_out3", state_out_share3, 128'h0);
    chk("reset_sb_in", 128'({sb_in_share1, sb_in_share2, sb_in_share3}), 128'h0);
    rst = 1'b0;
    tick();

    // Unmasked S-box row 0, continuous randomness.
    dc = done_cnt;
    run('0, '0, SEQ_ROW0, 99, 0, 1'b0, lat);
    chk("s1_latency", 128'(lat), 128'd20);
    chk("s1_result", state_out_share1 ^ state_out_share2 ^ state_out_share3, LIT_ROW0);
    tick(); tick();
    chk("s1_done_pulses", 128'(done_cnt - dc), 128'd1);

    // Masked zero state: every unmasked byte maps to 0x63.
    ra = {$urandom, $urandom, $urandom, $urandom};
    rb = {$urandom, $urandom, $urandom, $urandom};
    run(ra, rb, ra ^ rb, 99, 0, 1'b0, lat);
    chk("s2_latency", 128'(lat), 128'd20);
    chk("s2_result", state_out_share1 ^ state_out_share2 ^ state_out_share3, ALL_63);
    chk("s2_share1_masked", 128'(state_out_share1 == ALL_63), 128'h0);
    chk("s2_share2_masked", 128'(state_out_share2 == ALL_63), 128'h0);
    chk("s2_share3_masked", 128'(state_out_share3 == ALL_63), 128'h0);
    tick(); tick();

    // Five stall cycles after the fourth issue.
    run('0, '0, SEQ_ROW0, 4, 5, 1'b0, lat);
    chk("s3_latency", 128'(lat), 128'd25);
    chk("s3_result", state_out_share1 ^ state_out_share2 ^ state_out_share3, LIT_ROW0);
    tick(); tick();

    // Reset in the middle of a run.
    dc = done_cnt;
    state_in_share1 = '0; state_in_share2 = '0; state_in_share3 = SEQ_ROW1;
    start = 1'b1; rand_valid = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s4_busy_after_rst", 128'(busy), 128'h0);
    chk("s4_out1_after_rst", state_out_share1, 128'h0);
    chk("s4_out2_after_rst", state_out_share2, 128'h0);
    chk("s4_out3_after_rst", state_out_share3, 128'h0);
    for (int i = 0; i < 8; i++) tick();
    chk("s4_no_done", 128'(done_cnt - dc), 128'h0);
    run('0, '0, SEQ_ROW0, 99, 0, 1'b0, lat);
    chk("s4_fresh_latency", 128'(lat), 128'd20);
    chk("s4_fresh_result", state_out_share1 ^ state_out_share2 ^ state_out_share3, LIT_ROW0);
    tick(); tick();

    // Second start while busy must be ignored.
    dc = done_cnt;
    ra = {$urandom, $urandom, $urandom, $urandom};
    run(ra, ~ra, ~SEQ_ROW0, 99, 0, 1'b1, lat);
    chk("s5_latency", 128'(lat), 128'd20);
    chk("s5_result", state_out_share1 ^ state_out_share2 ^ state_out_share3, LIT_ROW0);
    tick(); tick(); tick();
    chk("s5_done_pulses", 128'(done_cnt - dc), 128'd1);

    // Back-to-back: start held through the done cycle is accepted only in IDLE.
    dc = done_cnt;
    run('0, '0, SEQ_ROW0, 99, 0, 1'b0, lat);
    chk("s6_first_result", state_out_share1 ^ state_out_share2 ^ state_out_share3, LIT_ROW0);
    ra = {$urandom, $urandom, $urandom, $urandom};
    rb = {$urandom, $urandom, $urandom, $urandom};
    state_in_share1 = ra; state_in_share2 = rb; state_in_share3 = ra ^ rb ^ SEQ_ROW1;
    start = 1'b1;
    tick();
    chk("s6_idle_after_done", 128'(busy), 128'h0);
    run(ra, rb, ra ^ rb ^ SEQ_ROW1, 99, 0, 1'b0, lat);
    chk("s6_second_latency", 128'(lat), 128'd20);
    chk("s6_second_result", state_out_share1 ^ state_out_share2 ^ state_out_share3, LIT_ROW1);
    tick(); tick();
    chk("s6_done_pulses", 128'(done_cnt - dc), 128'd2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
